// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset fetch address and fetch FSM encodings.
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} pairs; the head is read straight from storage.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, runs the imem req/ack handshake,
// buffers returned words and handles redirects from the core.
//   state | meaning
//   IDLE  | no request outstanding, waiting for a free FIFO slot
//   FETCH | request outstanding, its data will be kept
//   DROP  | request issued before a redirect still outstanding, its data is discarded
module fetch_unit #(
    parameter int              XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus
);
    import core_pkg::*;

    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_t    state;
    fetch_state_t    state_n;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] next_pc_n;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_addr_n;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_after;
    logic [2*XLEN-1:0] head;
    logic            ack;
    logic            push;
    logic            pop;

    // An ack only means something while a request is outstanding.
    assign ack         = imem_ack && (state != IDLE);
    assign pop         = instr_valid && instr_ready && !redirect;
    assign push        = ack && (state == FETCH) && !redirect;
    assign count_after = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            next_pc  <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_n;
            next_pc  <= next_pc_n;
            req_addr <= req_addr_n;
        end
    end

    always_comb begin
        state_n    = state;
        next_pc_n  = next_pc;
        req_addr_n = req_addr;
        if (redirect) begin
            // A pending request must still complete on the bus before the new target is fetched.
            if ((state != IDLE) && !ack) begin
                state_n   = DROP;
                next_pc_n = redirect_pc;
            end else begin
                state_n    = FETCH;
                req_addr_n = redirect_pc;
                next_pc_n  = redirect_pc + 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (count < FULL) begin
                        state_n    = FETCH;
                        req_addr_n = next_pc;
                        next_pc_n  = next_pc + 1'b1;
                    end
                end
                FETCH: begin
                    if (ack) begin
                        if (count_after < FULL) begin
                            req_addr_n = next_pc;
                            next_pc_n  = next_pc + 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (ack) begin
                        state_n    = FETCH;
                        req_addr_n = next_pc;
                        next_pc_n  = next_pc + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH(2 * XLEN),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(redirect),
        .data ({imem_rdata, req_addr}),
        .count(count),
        .head (head)
    );

    assign imem_req      = (state != IDLE);
    assign imem_addr     = req_addr;
    assign instr_valid   = (count != '0);
    assign instr         = head[2*XLEN-1:XLEN];
    assign instr_pc      = head[XLEN-1:0];
    assign instr_pc_plus = instr_valid ? (instr_pc + 1'b1) : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected PCs, a negedge monitor checks every consumed word.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // Memory contents: every word is tagged with its own address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC0DE_0000 + a;
    endfunction

    assign imem_rdata = word(imem_addr);

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_pc_plus(instr_pc_plus)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst && instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_instr: got pc %h expected no instruction", instr_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("mon_pc", instr_pc, e);
                check("mon_instr", instr, word(e));
                check("mon_pc_plus", instr_pc_plus, e + 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Zero-wait acks for addresses 0..n-1 with instr_ready high; ends with address n outstanding.
    task automatic prefix(input int n);
        do_reset();
        for (int k = 0; k < n; k++) begin
            tick();
            check("seq_addr", imem_addr, k);
            check("seq_req", imem_req, 1);
            check("seq_valid", instr_valid, (k >= 1));
            imem_ack = 1'b1;
            exp_q.push_back(k);
        end
        tick();
        imem_ack = 1'b0;
        check("seq_last_addr", imem_addr, n);
        check("seq_last_valid", instr_valid, 1);
    endtask

    initial begin
        rst         = 1'b0;
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        #3;
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_pc_plus", instr_pc_plus, 0);

        // Streaming, one instruction per cycle.
        prefix(4);

        // Backpressure: FIFO fills, request stops until a slot frees.
        do_reset();
        instr_ready = 1'b0;
        tick();
        check("bp_addr0", imem_addr, 0);
        imem_ack = 1'b1;
        exp_q.push_back(0);
        tick();
        check("bp_addr1", imem_addr, 1);
        exp_q.push_back(1);
        tick();
        check("bp_full_req", imem_req, 0);
        check("bp_full_valid", instr_valid, 1);
        imem_ack = 1'b0;
        tick();
        check("bp_still_idle", imem_req, 0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("bp_head_adv", instr_pc, 1);
        check("bp_idle_after_pop", imem_req, 0);
        tick();
        check("bp_req_again", imem_req, 1);
        check("bp_addr2", imem_addr, 2);

        // Slow memory: address 5 held for three cycles.
        prefix(5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_req", imem_req, 1);
            check("wait_addr", imem_addr, 5);
            check("wait_valid", instr_valid, 0);
        end
        imem_ack = 1'b1;
        exp_q.push_back(5);
        tick();
        imem_ack = 1'b0;
        check("wait_valid_after_ack", instr_valid, 1);
        check("wait_pc", instr_pc, 5);

        // Redirect while address 5 is outstanding, retargeted while dropping.
        prefix(5);
        tick();
        check("rd_addr_pre", imem_addr, 5);
        check("rd_valid_pre", instr_valid, 0);
        redirect    = 1'b1;
        redirect_pc = 32'h30;
        tick();
        check("rd_drop_req", imem_req, 1);
        check("rd_drop_addr", imem_addr, 5);
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        check("rd_drop_addr2", imem_addr, 5);
        imem_ack = 1'b1;
        tick();
        check("rd_new_addr", imem_addr, 32'h40);
        check("rd_no_stale", instr_valid, 0);
        exp_q.push_back(32'h40);
        tick();
        imem_ack = 1'b0;
        check("rd_first_valid", instr_valid, 1);
        check("rd_first_pc", instr_pc, 32'h40);

        // Redirect with a full FIFO and ready high, then redirect coinciding with an ack.
        do_reset();
        instr_ready = 1'b0;
        tick();
        imem_ack = 1'b1;
        tick();
        tick();
        check("fl_full_valid", instr_valid, 1);
        check("fl_full_req", imem_req, 0);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        check("fl_flushed", instr_valid, 0);
        check("fl_req", imem_req, 1);
        check("fl_addr", imem_addr, 32'h80);
        tick();
        check("fl_valid80", instr_valid, 1);
        check("fl_pc80", instr_pc, 32'h80);
        redirect    = 1'b1;
        redirect_pc = 32'h90;
        tick();
        redirect = 1'b0;
        imem_ack = 1'b0;
        check("fl_ack_addr", imem_addr, 32'h90);
        check("fl_ack_discard", instr_valid, 0);
        tick();
        check("fl_ack_discard2", instr_valid, 0);
        check("fl_ack_req", imem_req, 1);
        check("fl_ack_addr2", imem_addr, 32'h90);

        // Asynchronous reset in the middle of an outstanding request.
        do_reset();
        instr_ready = 1'b0;
        tick();
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("ar_pre_valid", instr_valid, 1);
        check("ar_pre_addr", imem_addr, 1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_req", imem_req, 0);
        check("ar_valid", instr_valid, 0);
        check("ar_addr", imem_addr, 0);
        check("ar_instr", instr, 0);
        check("ar_pc", instr_pc, 0);
        check("ar_pc_plus", instr_pc_plus, 0);
        imem_ack = 1'b1;
        tick();
        check("ar_late_ack_req", imem_req, 0);
        check("ar_late_ack_valid", instr_valid, 0);
        imem_ack = 1'b0;
        rst      = 1'b1;
        tick();
        check("ar_restart_req", imem_req, 1);
        check("ar_restart_addr", imem_addr, 0);
        check("ar_restart_valid", instr_valid, 0);
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        exp_q.push_back(0);
        tick();
        imem_ack = 1'b0;
        check("ar_restart_got", instr_valid, 1);
        tick();
        tick();
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the single-cycle core. It owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/ack handshake. Returned words are buffered with their PC in a small FIFO and presented to the core's decode side over a valid/ready interface. Taken branches and jumps from the core arrive as a redirect, which flushes everything fetched past the redirect point.

## Interface
Parameters:
- XLEN, 32, datapath and address width
- RESET_PC, 0, first fetch address after reset
- DEPTH, 2, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_req  out  1  request outstanding
- imem_addr  out  XLEN  word address of outstanding request
- imem_ack  in  1  sampled at an edge with imem_req=1; completes the request
- imem_rdata  in  XLEN  instruction word, valid with imem_ack
- redirect  in  1  core-taken branch or jump, one-cycle pulse
- redirect_pc  in  XLEN  new fetch address, valid with redirect
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  core consumes head when instr_valid=1
- instr  out  XLEN  head instruction word
- instr_pc  out  XLEN  head instruction address
- instr_pc_plus  out  XLEN  instr_pc+1

## Operation
- PC is word-addressed and increments by 1, matching the core's PCPlus4 constant.
- Registers:
  - next_pc: next address to fetch
  - req_addr: drives imem_addr
  - state
  - FIFO with count
- At most one request outstanding. imem_req = (state != IDLE).
- States:
  - IDLE: no request. Moves to FETCH when count < DEPTH; req_addr ← next_pc, next_pc ← next_pc+1.
  - FETCH: req held, imem_addr stable until ack.
    - On ack without redirect: push {imem_rdata, req_addr}.
    - If count after push and pop < DEPTH, stay in FETCH with req_addr ← next_pc, next_pc+1. This gives back-to-back requests. Otherwise go to IDLE.
  - DROP: request issued before a redirect is still outstanding. req and addr are held, since the memory must see the transaction complete. On ack, the data is discarded and the state moves to FETCH with req_addr ← next_pc.
- Redirect, which has priority over everything:
  - Flush FIFO (count ← 0); next_pc ← redirect_pc.
  - In FETCH or DROP without ack → DROP.
  - In FETCH or DROP with ack in the same cycle → ack data discarded; FETCH at redirect_pc next cycle.
  - In IDLE → FETCH at redirect_pc.
  - A pop in the same cycle as a redirect is ignored; the flush wins.
  - A repeated redirect while in DROP updates next_pc; the latest target wins.
- Simultaneous push and pop: count is unchanged and the head advances.
- The FIFO never overflows. A request is only issued when a slot is guaranteed.
- Addresses wrap modulo 2^XLEN.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, instr_pc_plus=0
  - state=IDLE, next_pc=RESET_PC, count=0
- Reset assertion clears all outputs immediately, without waiting for a clock edge, including in the middle of a transaction. Any ack after reset is ignored.
- After reset release:
  - Edge 1: IDLE→FETCH; imem_req=1, imem_addr=RESET_PC.
  - Zero-wait ack at edge 2 → instr_valid=1 after edge 2.
- Ack-to-valid latency: the word is visible at the FIFO head immediately after the ack edge when the FIFO was empty.
- Steady-state throughput: one instruction per cycle with zero-wait memory and instr_ready=1.
- Redirect-to-first-valid latency:
  - No outstanding request: 1 cycle to issue plus memory latency.
  - Outstanding request: the old request's latency is added first.
- Outputs instr, instr_pc and instr_pc_plus are driven from FIFO storage; there is no combinational path from imem_rdata.

## Structure
- Shared package core_pkg holds:
  - XLEN
  - RESET_PC default
  - fetch state encodings (IDLE=2'd0, FETCH=2'd1, DROP=2'd2)
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of {instr, pc}.
  - Inputs: push, pop, flush.
  - Outputs: count, head.
  - Uses the same clk and rst.
- The fetch_unit body holds the FSM, PC registers and redirect logic.

## Test plan
- Reset release, ack every cycle, instr_ready=1:
  - imem_addr sequence 0,1,2,3.
  - instr_valid from cycle 2.
  - instr_pc 0,1,2 on consecutive cycles; instr_pc_plus = instr_pc+1.
- instr_ready=0, zero-wait memory:
  - Two acks fill the FIFO (count=2), then imem_req drops.
  - Addr 2 is not requested until one instr_ready pulse, after which req reasserts with addr 2.
- Ack delayed 3 cycles:
  - imem_req and imem_addr=5 stay stable for all 3 cycles.
  - instr_valid stays low until the edge after the ack.
- Redirect to 0x40 while addr 5 is outstanding:
  - State DROP; imem_addr stays 5 until ack.
  - Word 5 is never presented.
  - Next imem_addr=0x40; the first valid has instr_pc=0x40.
- Redirect to 0x80 in the same cycle as ack and instr_ready=1, with FIFO holding 2 entries:
  - FIFO empties; ack data is discarded.
  - Next imem_addr=0x80; no stale instr_valid.
- rst driven low between clock edges during an outstanding request:
  - imem_req=0 and instr_valid=0 immediately.
  - A late ack is ignored.
  - After release, the first imem_addr is RESET_PC.
